nios_system_cs_arbiter: RTL and testbench
=========================================

NIOS_SYSTEM_CS_ARBITER -- requirements
Module: nios_system_cs_arbiter

Interface
REQ-001 Parameter CNT_W, default 8: width of the SETUP and HOLD count registers.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: grant watchdog limit, used only when the macro in REQ-030 is defined.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 address  input  2  Avalon-MM register select.
REQ-006 chipselect  input  1  Avalon-MM slave select.
REQ-007 write_n  input  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  combinational read of the register at address; unused bits read 0.
REQ-010 req  input  2  per-requester access request, level-sensitive.
REQ-011 done  input  2  per-requester end-of-access pulse.
REQ-012 gnt  output  2  one-hot grant, or all zero.
REQ-013 cs_out  output  1  active-high chip select to the shared peripheral.

Function
REQ-014 Register map:
- addr0 CTRL: bit0 enable, R/W.
- addr1 SETUP: [CNT_W-1:0], R/W.
- addr2 HOLD: [CNT_W-1:0], R/W.
- addr3 STATUS: [1:0]=gnt, [2]=cs_out, [4:3]=state, [5]=last winner, [6]=timeout sticky; read-only except write-1-to-clear on bit6.
REQ-015 States, encoded in STATUS[4:3]: IDLE=0, SETUP=1, GRANT=2, HOLD=3.
REQ-016 IDLE: with enable=1 and any req bit set, the block picks a winner, sets cs_out=1 and loads the counter from SETUP on the same edge, then enters SETUP.
REQ-017 Winner selection is round-robin: on simultaneous requests the requester that did not win last time takes priority.
REQ-018 SETUP and HOLD values are latched at transaction start; register writes during a transaction affect only the next transaction.
REQ-019 SETUP state: gnt[winner] rises exactly N clocks after cs_out rises, where N is the latched SETUP value.
- N=0: gnt rises on the same edge as cs_out; SETUP is skipped and the block goes directly to GRANT.
REQ-020 GRANT: gnt stays asserted until either done[winner]=1 or req[winner]=0 is sampled; on that edge gnt clears and the state moves to HOLD.
REQ-021 done and req of the non-winning requester are ignored during a transaction.
REQ-022 HOLD state: cs_out falls exactly H clocks after gnt falls, where H is the latched HOLD value.
- H=0: cs_out falls on the same edge as gnt; the state returns to IDLE on that edge.
REQ-023 cs_out stays low for at least one full cycle between transactions.
REQ-024 gnt is never asserted while cs_out=0.
REQ-025 At most one gnt bit is asserted at any time.
REQ-026 Clearing enable mid-transaction does not abort the transaction; the block finishes it and does not start a new one.
REQ-027 The last winner updates at arbitration time.

Reset
REQ-028 Reset values:
- State IDLE; gnt=0; cs_out=0.
- CTRL.enable=1; SETUP=1; HOLD=1.
- Last winner = requester 1, so requester 0 wins first.
- Timeout sticky bit = 0.
REQ-029 Reset asserted mid-transaction: gnt and cs_out drop asynchronously in the same cycle, with no HOLD phase.

Configuration
REQ-030 Macro CS_ARB_TIMEOUT_EN.
- Defined: the counter runs in GRANT. If TIMEOUT_CYCLES clocks elapse without done or req drop, the block forces gnt=0, enters HOLD and sets STATUS[6].
- Undefined: GRANT waits indefinitely; STATUS[6] reads 0 and writes to it are ignored.

Verification
REQ-031 SETUP=2, HOLD=3; pulse req0 then done0 at cycle 10 -> cs_out rises at cycle 1, gnt=01 at cycle 3, gnt=00 at cycle 11, cs_out falls at cycle 14.
REQ-032 After reset, hold req=11 continuously and pulse done each grant -> gnt sequence 01,10,01,10; a cs_out low gap of at least 1 cycle between grants.
REQ-033 SETUP=0, HOLD=0; req1 -> gnt=10 and cs_out rise on the same edge; drop req1 -> both fall on the same edge.
REQ-034 Write SETUP=5 during GRANT of the current transaction -> the current transaction is unchanged; the next transaction shows a 5-cycle setup.
REQ-035 With CS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, req0 held with no done -> gnt falls 16 cycles after it rose and STATUS reads bit6=1; writing 0x40 to addr3 clears bit6.
REQ-036 Assert reset during SETUP and again during GRANT -> gnt=0 and cs_out=0 within the same cycle; STATUS reads state=0.

Source files
------------

// File: rtl/nios_system_cs_arbiter.sv
// Two-requester chip-select arbiter with programmable setup/hold timing and an Avalon-MM register block.
// Optional grant watchdog is compiled in with `define CS_ARB_TIMEOUT_EN.
module nios_system_cs_arbiter #(
  parameter int CNT_W          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [1:0]  req,
  input  logic [1:0]  done,
  output logic [1:0]  gnt,
  output logic        cs_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_GRANT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             enable_q, enable_d;
  logic [CNT_W-1:0] setup_q, setup_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] hold_lat_q, hold_lat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             cs_q, cs_d;
  logic             tmo_q, tmo_d;

  logic             wr_en;
  logic             win;
  logic [1:0]       win_oh;
  logic             release_req;
  logic             wdog_exp;
  logic             unused_ok;

  assign wr_en       = chipselect & ~write_n;
  assign unused_ok   = ^writedata;
  // last_q doubles as the current winner while a transaction is in flight.
  assign release_req = done[last_q] | ~req[last_q];

  always_comb begin
    if (req[0] && req[1]) win = ~last_q;
    else                  win = req[1];
  end
  assign win_oh = win ? 2'b10 : 2'b01;

`ifdef CS_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wdog_q, wdog_d;
  assign wdog_exp = (wdog_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  logic unused_param;
  assign unused_param = (TIMEOUT_CYCLES > 0);
  assign wdog_exp     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    enable_d   = enable_q;
    setup_d    = setup_q;
    hold_d     = hold_q;
    hold_lat_d = hold_lat_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    gnt_d      = gnt_q;
    cs_d       = cs_q;
    tmo_d      = tmo_q;
`ifdef CS_ARB_TIMEOUT_EN
    wdog_d     = wdog_q;
`endif

    if (wr_en) begin
      case (address)
        2'd0: enable_d = writedata[0];
        2'd1: setup_d  = writedata[CNT_W-1:0];
        2'd2: hold_d   = writedata[CNT_W-1:0];
        default: begin
`ifdef CS_ARB_TIMEOUT_EN
          if (writedata[6]) tmo_d = 1'b0;
`endif
        end
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (enable_q && (req != 2'b00)) begin
          last_d     = win;
          cs_d       = 1'b1;
          hold_lat_d = hold_q;
          cnt_d      = setup_q;
`ifdef CS_ARB_TIMEOUT_EN
          wdog_d     = '0;
`endif
          if (setup_q == '0) begin
            gnt_d   = win_oh;
            state_d = S_GRANT;
          end else begin
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q <= CNT_W'(1)) begin
          gnt_d   = last_q ? 2'b10 : 2'b01;
          state_d = S_GRANT;
`ifdef CS_ARB_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GRANT: begin
        if (release_req || wdog_exp) begin
          gnt_d = 2'b00;
          if (wdog_exp && !release_req) tmo_d = 1'b1;
          if (hold_lat_q == '0) begin
            cs_d    = 1'b0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = hold_lat_q;
            state_d = S_HOLD;
          end
        end else begin
`ifdef CS_ARB_TIMEOUT_EN
          wdog_d = wdog_q + TW'(1);
`endif
        end
      end
      default: begin
        if (cnt_q <= CNT_W'(1)) begin
          cs_d    = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      enable_q   <= 1'b1;
      setup_q    <= CNT_W'(1);
      hold_q     <= CNT_W'(1);
      hold_lat_q <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      gnt_q      <= 2'b00;
      cs_q       <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      enable_q   <= enable_d;
      setup_q    <= setup_d;
      hold_q     <= hold_d;
      hold_lat_q <= hold_lat_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      cs_q       <= cs_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[0]         = enable_q;
      2'd1:    readdata[CNT_W-1:0] = setup_q;
      2'd2:    readdata[CNT_W-1:0] = hold_q;
      default: readdata[6:0]       = {tmo_q, last_q, state_q, cs_q, gnt_q};
    endcase
  end

  assign gnt    = gnt_q;
  assign cs_out = cs_q;

endmodule

// File: tb/tb_nios_system_cs_arbiter.sv
// Directed bench for nios_system_cs_arbiter: timing, round robin, latching, enable, watchdog/status bit, reset.
module tb_nios_system_cs_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  req;
  logic [1:0]  done;
  logic [1:0]  gnt;
  logic        cs_out;

  int checks = 0;
  int errors = 0;

  nios_system_cs_arbiter #(.CNT_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .req(req), .done(done), .gnt(gnt), .cs_out(cs_out)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1; req = 2'b00; done = 2'b00; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = '0;
    #3;
    checks++;
    if (gnt !== 2'b00 || cs_out !== 1'b0) begin
      errors++; $display("FAIL reset_outputs gnt=%b cs=%b expected 00/0", gnt, cs_out);
    end
    rd(2'd0, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl got %h expected 1", d); end
    rd(2'd1, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL reset_setup got %h expected 1", d); end
    rd(2'd2, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL reset_hold got %h expected 1", d); end
    rd(2'd3, d); checks++;
    if (d !== 32'h20) begin errors++; $display("FAIL reset_status got %h expected 20", d); end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_basic_timing;
    logic [31:0] d;
    logic [1:0]  eg;
    logic        ec;
    wr(2'd1, 32'd2);
    wr(2'd2, 32'd3);
    for (int c = 1; c <= 15; c++) begin
      req  = (c <= 11) ? 2'b01 : 2'b00;
      done = (c == 11) ? 2'b01 : 2'b00;
      tick;
      eg = (c >= 3 && c <= 10) ? 2'b01 : 2'b00;
      ec = (c >= 1 && c <= 13);
      checks++;
      if (gnt !== eg || cs_out !== ec) begin
        errors++; $display("FAIL basic_cycle%0d gnt=%b cs=%b expected %b/%b", c, gnt, cs_out, eg, ec);
      end
    end
    done = 2'b00;
    rd(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL basic_status got %h expected 0", d); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_seq [4];
    int found;
    logic saw_low;
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;
    reset = 1'b1; #2; reset = 1'b0;
    found = 0; saw_low = 1'b0;
    req = 2'b11; done = 2'b00;
    for (int c = 0; c < 80 && found < 4; c++) begin
      tick;
      done = 2'b00;
      if (gnt !== 2'b00) begin
        checks++;
        if (gnt !== exp_seq[found]) begin
          errors++; $display("FAIL rr_grant%0d got %b expected %b", found, gnt, exp_seq[found]);
        end
        if (found > 0) begin
          checks++;
          if (saw_low !== 1'b1) begin
            errors++; $display("FAIL rr_gap%0d cs low gap seen=%b expected 1", found, saw_low);
          end
        end
        done = gnt;
        found++;
        saw_low = 1'b0;
      end else if (cs_out === 1'b0) begin
        saw_low = 1'b1;
      end
    end
    checks++;
    if (found != 4) begin errors++; $display("FAIL rr_count got %0d grants expected 4", found); end
    req = 2'b00; done = 2'b00;
    repeat (6) tick;
  endtask

  task automatic test_zero_timing;
    logic [31:0] d;
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd0);
    req = 2'b10;
    tick; checks++;
    if (gnt !== 2'b10 || cs_out !== 1'b1) begin
      errors++; $display("FAIL zero_rise gnt=%b cs=%b expected 10/1", gnt, cs_out);
    end
    rd(2'd3, d); checks++;
    if (d[4:3] !== 2'd2) begin errors++; $display("FAIL zero_state got %0d expected 2", d[4:3]); end
    req = 2'b11; done = 2'b01;
    tick; checks++;
    if (gnt !== 2'b10 || cs_out !== 1'b1) begin
      errors++; $display("FAIL zero_ignore_other gnt=%b cs=%b expected 10/1", gnt, cs_out);
    end
    req = 2'b00; done = 2'b00;
    tick; checks++;
    if (gnt !== 2'b00 || cs_out !== 1'b0) begin
      errors++; $display("FAIL zero_fall gnt=%b cs=%b expected 00/0", gnt, cs_out);
    end
    tick;
  endtask

  task automatic test_latch;
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd1);
    req = 2'b01;
    tick;
    tick; checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL latch_first_gnt got %b expected 01", gnt); end
    wr(2'd1, 32'd5);
    wr(2'd2, 32'd4);
    checks++;
    if (gnt !== 2'b01 || cs_out !== 1'b1) begin
      errors++; $display("FAIL latch_hold_grant gnt=%b cs=%b expected 01/1", gnt, cs_out);
    end
    req = 2'b00;
    tick; checks++;
    if (gnt !== 2'b00 || cs_out !== 1'b1) begin
      errors++; $display("FAIL latch_first_release gnt=%b cs=%b expected 00/1", gnt, cs_out);
    end
    tick; checks++;
    if (cs_out !== 1'b0) begin errors++; $display("FAIL latch_first_hold cs=%b expected 0", cs_out); end
    req = 2'b01;
    tick; checks++;
    if (cs_out !== 1'b1 || gnt !== 2'b00) begin
      errors++; $display("FAIL latch_second_start gnt=%b cs=%b expected 00/1", gnt, cs_out);
    end
    for (int k = 1; k <= 5; k++) begin
      tick; checks++;
      if (gnt !== ((k == 5) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL latch_setup5_k%0d gnt=%b", k, gnt);
      end
    end
    req = 2'b00;
    tick;
    for (int k = 1; k <= 4; k++) begin
      tick; checks++;
      if (cs_out !== (k < 4)) begin
        errors++; $display("FAIL latch_hold4_k%0d cs=%b expected %b", k, cs_out, (k < 4));
      end
    end
  endtask

  task automatic test_enable;
    logic [31:0] d;
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd1);
    req = 2'b01;
    tick;
    wr(2'd0, 32'd0);
    checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL enable_midgrant gnt=%b expected 01", gnt); end
    req = 2'b00;
    tick;
    tick; checks++;
    if (cs_out !== 1'b0) begin errors++; $display("FAIL enable_finish cs=%b expected 0", cs_out); end
    req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      tick; checks++;
      if (cs_out !== 1'b0 || gnt !== 2'b00) begin
        errors++; $display("FAIL enable_blocked%0d gnt=%b cs=%b expected 00/0", k, gnt, cs_out);
      end
    end
    req = 2'b00;
    wr(2'd0, 32'd1);
    rd(2'd0, d); checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL enable_readback got %h expected 1", d); end
  endtask

  task automatic test_timeout;
    logic [31:0] d;
`ifdef CS_ARB_TIMEOUT_EN
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd1);
    req = 2'b01;
    tick;
    tick; checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL tmo_grant gnt=%b expected 01", gnt); end
    for (int k = 1; k <= 16; k++) begin
      tick; checks++;
      if (gnt !== ((k < 16) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL tmo_k%0d gnt=%b", k, gnt);
      end
    end
    req = 2'b00;
    rd(2'd3, d); checks++;
    if (d[6] !== 1'b1) begin errors++; $display("FAIL tmo_sticky got %b expected 1", d[6]); end
    wr(2'd3, 32'h40);
    rd(2'd3, d); checks++;
    if (d[6] !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b expected 0", d[6]); end
    repeat (3) tick;
`else
    wr(2'd3, 32'h40);
    rd(2'd3, d); checks++;
    if (d[6] !== 1'b0) begin errors++; $display("FAIL tmo_disabled got %b expected 0", d[6]); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    wr(2'd1, 32'd3);
    req = 2'b01;
    tick; checks++;
    if (cs_out !== 1'b1 || gnt !== 2'b00) begin
      errors++; $display("FAIL rstmid_setup_entry gnt=%b cs=%b expected 00/1", gnt, cs_out);
    end
    reset = 1'b1;
    #1; checks++;
    if (gnt !== 2'b00 || cs_out !== 1'b0) begin
      errors++; $display("FAIL rstmid_setup gnt=%b cs=%b expected 00/0", gnt, cs_out);
    end
    rd(2'd3, d); checks++;
    if (d !== 32'h20) begin errors++; $display("FAIL rstmid_setup_status got %h expected 20", d); end
    reset = 1'b0;
    tick;
    tick;
    tick; checks++;
    if (gnt !== 2'b01) begin errors++; $display("FAIL rstmid_grant_entry gnt=%b expected 01", gnt); end
    reset = 1'b1;
    #1; checks++;
    if (gnt !== 2'b00 || cs_out !== 1'b0) begin
      errors++; $display("FAIL rstmid_grant gnt=%b cs=%b expected 00/0", gnt, cs_out);
    end
    rd(2'd3, d); checks++;
    if (d !== 32'h20) begin errors++; $display("FAIL rstmid_grant_status got %h expected 20", d); end
    reset = 1'b0;
    req = 2'b00;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic_timing;
    test_round_robin;
    test_zero_timing;
    test_latch;
    test_enable;
    test_timeout;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
